// File: rtl/game_round_ctrl.sv
// Round controller for the binary mental-math game: draws a non-repeating target
// from the free-running RNG, times the player's answer and keeps score.
module game_round_ctrl #(
    parameter int unsigned ROUNDS     = 10,
    parameter int unsigned TIME_LIMIT = 200,
    parameter int unsigned TW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rnd_in,
    output logic       rng_en,
    input  logic [3:0] ans_in,
    input  logic       submit,
    output logic [3:0] target,
    output logic [3:0] score,
    output logic [3:0] round_cnt,
    output logic       hit,
    output logic       miss,
    output logic       timeout,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        ASK,
        RESULT,
        OVER
    } state_t;

    state_t        state;
    logic          start_d;
    logic          submit_d;
    logic          first_round;
    logic [TW-1:0] timer;

    logic start_rise;
    logic submit_rise;

    assign start_rise  = start & ~start_d;
    assign submit_rise = submit & ~submit_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            start_d     <= 1'b0;
            submit_d    <= 1'b0;
            first_round <= 1'b1;
            timer       <= '0;
            rng_en      <= 1'b0;
            target      <= '0;
            score       <= '0;
            round_cnt   <= '0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_d  <= start;
            submit_d <= submit;
            rng_en   <= 1'b1;
            hit      <= 1'b0;
            miss     <= 1'b0;
            timeout  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= DRAW;
                        busy  <= 1'b1;
                    end
                end

                // A repeat just stalls; the RNG moves on by the next cycle.
                DRAW: begin
                    if (first_round || rnd_in != target) begin
                        target      <= rnd_in;
                        first_round <= 1'b0;
                        timer       <= '0;
                        state       <= ASK;
                    end
                end

                // A submit on the expiry cycle takes precedence over the timeout.
                ASK: begin
                    if (submit_rise) begin
                        if (ans_in == target) begin
                            hit   <= 1'b1;
                            score <= score + 4'd1;
                        end else begin
                            miss <= 1'b1;
                        end
                        state <= RESULT;
                    end else if (timer == TW'(TIME_LIMIT - 1)) begin
                        miss    <= 1'b1;
                        timeout <= 1'b1;
                        state   <= RESULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                RESULT: begin
                    round_cnt <= round_cnt + 4'd1;
                    if (round_cnt == 4'(ROUNDS - 1)) begin
                        state     <= OVER;
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        state <= DRAW;
                    end
                end

                OVER: begin
                    if (start_rise) begin
                        score       <= '0;
                        round_cnt   <= '0;
                        first_round <= 1'b1;
                        state       <= DRAW;
                        busy        <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with ROUNDS=3, TIME_LIMIT=4; the RNG is
// replaced by values driven straight onto rnd_in.
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] rnd_in;
    logic       rng_en;
    logic [3:0] ans_in;
    logic       submit;
    logic [3:0] target;
    logic [3:0] score;
    logic [3:0] round_cnt;
    logic       hit;
    logic       miss;
    logic       timeout;
    logic       busy;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    game_round_ctrl #(
        .ROUNDS    (3),
        .TIME_LIMIT(4),
        .TW        (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rnd_in   (rnd_in),
        .rng_en   (rng_en),
        .ans_in   (ans_in),
        .submit   (submit),
        .target   (target),
        .score    (score),
        .round_cnt(round_cnt),
        .hit      (hit),
        .miss     (miss),
        .timeout  (timeout),
        .busy     (busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return 32'({target, score, round_cnt, hit, miss, timeout, busy, game_over, rng_en});
    endfunction

    initial begin
        int hits;
        int misses;
        int touts;
        int cyc;
        int rounds;
        logic       prev_valid;
        logic [3:0] prev_t;

        // Reset with arbitrary inputs applied
        rst = 1'b0; start = 1'b1; submit = 1'b1; ans_in = 4'hf; rnd_in = 4'd7;
        tick(); tick();
        check("reset_all_zero", all_out(), 32'h0);
        start = 1'b0; submit = 1'b0; ans_in = 4'h0;
        rst = 1'b1;
        tick();
        check("idle_flags", 32'({busy, game_over, rng_en}), 32'b001);

        // Game 1, round 1: correct answer
        rnd_in = 4'd5; start = 1'b1;
        tick();
        check("start_busy", 32'(busy), 32'd1);
        check("target_before_draw", 32'(target), 32'd0);
        tick();
        check("target_latched_5", 32'(target), 32'd5);
        ans_in = 4'b0101; submit = 1'b1;
        tick();
        check("r1_hit_miss_score_rc", 32'({hit, miss, score, round_cnt}), 32'({1'b1, 1'b0, 4'd1, 4'd0}));
        tick();
        check("r1_hit_gone_rc", 32'({hit, round_cnt, busy}), 32'({1'b0, 4'd1, 1'b1}));

        // Round 2: repeat stall for 3 cycles, then new value
        tick(); tick(); tick();
        check("stall_target_held", 32'(target), 32'd5);
        rnd_in = 4'd9;
        tick();
        check("stall_then_latch", 32'(target), 32'd9);

        // Submit still held from round 1: no event until timeout
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            hits += int'(hit) + int'(miss) + int'(timeout);
        end
        check("held_submit_no_event", 32'(hits), 32'd0);
        tick();
        check("timeout_pulse", 32'({hit, miss, timeout, score}), 32'({1'b0, 1'b1, 1'b1, 4'd1}));
        submit = 1'b0; rnd_in = 4'd3;
        tick();
        check("timeout_pulse_one_cycle", 32'({miss, timeout, round_cnt}), 32'({1'b0, 1'b0, 4'd2}));
        tick();
        check("r3_target", 32'(target), 32'd3);

        // Round 3: correct submit exactly on the expiry cycle
        tick(); tick(); tick();
        ans_in = 4'd3; submit = 1'b1;
        tick();
        check("expiry_submit_hit", 32'({hit, miss, timeout, score}), 32'({1'b1, 1'b0, 1'b0, 4'd2}));
        tick();
        check("game_over_rise", 32'({game_over, busy, round_cnt}), 32'({1'b1, 1'b0, 4'd3}));
        tick();
        check("over_hold", 32'({game_over, score, target}), 32'({1'b1, 4'd2, 4'd3}));

        // Game 2: restart from OVER, wrong answer then held button
        start = 1'b0;
        tick();
        start = 1'b1; rnd_in = 4'd3;
        tick();
        check("restart_clear", 32'({busy, game_over, score, round_cnt}), 32'({1'b1, 1'b0, 4'd0, 4'd0}));
        tick();
        check("restart_target_first_round", 32'(target), 32'd3);
        submit = 1'b0;
        tick();
        ans_in = 4'b0110; submit = 1'b1;
        tick();
        check("wrong_answer_miss", 32'({hit, miss, timeout, score}), 32'({1'b0, 1'b1, 1'b0, 4'd0}));
        hits = 0; misses = 0; touts = 0;
        for (int i = 0; i < 20; i++) begin
            rnd_in = 4'(4 + i % 8);
            tick();
            hits   += int'(hit);
            misses += int'(miss);
            touts  += int'(timeout & miss);
        end
        check("held_hits", 32'(hits), 32'd0);
        check("held_misses", 32'(misses), 32'd2);
        check("held_timeouts", 32'(touts), 32'd2);
        check("game2_end", 32'({game_over, score, round_cnt}), 32'({1'b1, 4'd0, 4'd3}));

        // Game 3: reset asserted in ASK
        submit = 1'b0; start = 1'b0;
        tick();
        start = 1'b1; rnd_in = 4'd8;
        tick(); tick();
        check("mid_game_busy", 32'({busy, target}), 32'({1'b1, 4'd8}));
        rst = 1'b0;
        tick();
        check("mid_game_reset", all_out(), 32'h0);
        rst = 1'b1; start = 1'b0;
        tick();

        // Random games, all rounds timing out; target must not repeat within a game
        for (int g = 0; g < 34; g++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            prev_valid = 1'b0; prev_t = 4'd0; rounds = 0; cyc = 0;
            while (!game_over && cyc < 200) begin
                rnd_in = (prev_valid && $urandom_range(0, 1) == 1) ? prev_t : 4'($urandom_range(0, 14));
                tick();
                cyc++;
                if (miss) begin
                    if (prev_valid) begin
                        checks++;
                        assert (target !== prev_t) else begin
                            errors++;
                            $error("FAIL norepeat: observed=%0h expected!=%0h", target, prev_t);
                        end
                    end
                    prev_t = target; prev_valid = 1'b1; rounds++;
                end
            end
            check("rand_game_rounds", 32'({game_over, 4'(rounds), round_cnt}), 32'({1'b1, 4'd3, 4'd3}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
